block_ula_mc: RTL and testbench
===============================

BLOCK_ULA_MC -- requirements
Module: block_ula_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand and result width, at least 2.
REQ-002 Parameter COMP_DEPTH, default 16: entries in the internal comparison-flag stack, at least 2.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 DATA_IN  in  DATA_WIDTH  operand source for both operand registers.
REQ-006 CTRL_REG_OP1 / CTRL_REG_OP2  in  1 each  load OP1 / OP2 from DATA_IN.
REQ-007 START  in  1  operation request.
REQ-008 SEL_ULA  in  4  opcode; sampled with START.
REQ-009 CTRL_COMP_POP  in  1  pop the comparison-flag stack.
REQ-010 ULA_OUT  out  DATA_WIDTH  registered result.
REQ-011 OVERFLOW_OUT  out  1  registered overflow flag of the last operation.
REQ-012 BUSY / DONE  out  1 each  operation in progress / one-cycle completion pulse.
REQ-013 COMP_TOP, COMP_EMPTY, COMP_FULL, COMP_ERR  out  1 each  stack top flag, empty, full, sticky error.

Function
REQ-014 Operand registers SHALL load only while BUSY=0; loads requested while BUSY=1 SHALL be ignored.
REQ-015 If CTRL_REG_OP1 and CTRL_REG_OP2 are high in the same cycle, both registers SHALL load DATA_IN.
REQ-016 FSM states SHALL be IDLE, EXEC, MUL, DONE.
  - IDLE: START=1 latches SEL_ULA, then goes to MUL for opcode 0010 and to EXEC otherwise.
  - EXEC: lasts 1 cycle, then DONE.
  - MUL: lasts exactly DATA_WIDTH cycles of shift-add, then DONE.
  - DONE: lasts 1 cycle, then IDLE.
REQ-017 BUSY SHALL be 1 in EXEC and MUL; DONE SHALL be 1 only in the DONE state.
REQ-018 ULA_OUT and OVERFLOW_OUT SHALL update on the edge that enters DONE and hold until the next operation.
REQ-019 Latency: START sampled at the end of cycle 0 gives DONE in cycle 2 for non-multiply ops and in cycle DATA_WIDTH+1 for multiply.
REQ-020 START SHALL be ignored outside IDLE, including during DONE.
REQ-021 Opcodes, with A=OP2 and B=OP1:
  - 0000 A+B
  - 0001 A-B
  - 0010 A*B, low DATA_WIDTH bits
  - 0011 A<<B
  - 0100 A>>B
  - 0101 OR; 0110 AND; 0111 XOR
  - 1000 ~B
  - 1001 ==; 1010 !=; 1011 >; 1100 <; 1101 >=; 1110 <= (all unsigned)
  - 1111 NOP
REQ-022 Overflow SHALL be 1 for:
  - add with carry out;
  - sub with A<B;
  - mult with a nonzero upper product half;
  - lshift with any 1 bit shifted out.
  It SHALL be 0 for all other opcodes.
REQ-023 A shift amount of DATA_WIDTH or more SHALL give result 0; for lshift, overflow = (A!=0).
REQ-024 Comparison opcodes SHALL leave ULA_OUT unchanged, set OVERFLOW_OUT=0, and push the flag on entry to DONE.
REQ-025 NOP SHALL set ULA_OUT=0 and OVERFLOW_OUT=0.
REQ-026 Stack push with COMP_FULL=1 SHALL be dropped and SHALL set COMP_ERR.
REQ-027 CTRL_COMP_POP SHALL be honoured only when BUSY=0 and COMP_EMPTY=0.
  - Pop with COMP_EMPTY=1 SHALL set COMP_ERR.
  - Pop while BUSY=1 SHALL be ignored.
REQ-028 COMP_TOP SHALL show the most recent unpopped flag, and 0 when the stack is empty.
REQ-029 COMP_ERR SHALL be cleared only by rst.

Reset
REQ-030 With rst=1 at an edge, the block SHALL afterwards be:
  - FSM in IDLE;
  - OP1=OP2=0, ULA_OUT=0;
  - OVERFLOW_OUT, BUSY, DONE, COMP_TOP, COMP_FULL, COMP_ERR all 0;
  - COMP_EMPTY=1, stack cleared.
REQ-031 Reset mid-operation SHALL abort the operation, produce no DONE pulse and push no flag.
REQ-032 Reset SHALL take priority over START, loads and pop in the same cycle.

Verification (DATA_WIDTH=8, COMP_DEPTH=16)
REQ-033 OP2=200, OP1=100, add -> DONE in cycle 2, ULA_OUT=44, OVERFLOW_OUT=1.
REQ-034 OP2=20, OP1=13, mult -> BUSY for cycles 1-8, DONE in cycle 9, ULA_OUT=4, OVERFLOW_OUT=1.
REQ-035 Shifts:
  - 0x81<<1 -> ULA_OUT=0x02, OVERFLOW_OUT=1;
  - 0x81>>9 -> ULA_OUT=0, OVERFLOW_OUT=0.
REQ-036 17 consecutive '==' ops on equal operands:
  - COMP_FULL=1 after the 16th, 17th dropped, COMP_ERR=1;
  - 16 pops -> COMP_EMPTY=1;
  - a further pop leaves COMP_ERR=1.
REQ-037 START held during an active mult, plus rst in cycle 4 -> no second op; BUSY=0, ULA_OUT=0 from cycle 5, no DONE pulse.

Source files
------------

// File: rtl/block_ula_mc.sv
// Multi-cycle ALU with shift-add multiplier and a comparison-flag stack.
// Ports: clk/rst, DATA_IN + OP1/OP2 loads, START/SEL_ULA, CTRL_COMP_POP,
//        ULA_OUT/OVERFLOW_OUT, BUSY/DONE, COMP_TOP/EMPTY/FULL/ERR.
module block_ula_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int COMP_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  CTRL_REG_OP1,
  input  logic                  CTRL_REG_OP2,
  input  logic                  START,
  input  logic [3:0]            SEL_ULA,
  input  logic                  CTRL_COMP_POP,
  output logic [DATA_WIDTH-1:0] ULA_OUT,
  output logic                  OVERFLOW_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  COMP_TOP,
  output logic                  COMP_EMPTY,
  output logic                  COMP_FULL,
  output logic                  COMP_ERR
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam int SW = $clog2(COMP_DEPTH + 1);
  localparam logic [W-1:0]  W_L   = W'(W);
  localparam logic [CW-1:0] LAST  = CW'(W - 1);
  localparam logic [SW-1:0] FULLN = SW'(COMP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_MUL, S_DONE
  } state_t;

  state_t state, state_n;

  logic [W-1:0]   op1, op2;
  logic [3:0]     op;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] prod, mcand, prod_n;
  logic [W-1:0]   mplier;

  logic [COMP_DEPTH-1:0] stk, stk_sh;
  logic [SW-1:0]         scnt;

  logic [W-1:0]   a, b, res;
  logic [W:0]     sum;
  logic [2*W-1:0] wide;
  logic           big, ovf, is_cmp, flag;

  assign a    = op2;
  assign b    = op1;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign wide = {{W{1'b0}}, a} << b;
  assign big  = (b >= W_L);

  assign prod_n = prod + (mplier[0] ? mcand : '0);

  assign BUSY = (state == S_EXEC) || (state == S_MUL);
  assign DONE = (state == S_DONE);

  assign COMP_EMPTY = (scnt == '0);
  assign COMP_FULL  = (scnt == FULLN);
  assign stk_sh     = stk >> (scnt - SW'(1));
  assign COMP_TOP   = COMP_EMPTY ? 1'b0 : stk_sh[0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (START)
          state_n = (SEL_ULA == 4'b0010) ? S_MUL : S_EXEC;
      S_EXEC: state_n = S_DONE;
      S_MUL:  if (cnt == LAST) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Single-cycle ops; comparisons keep ULA_OUT and only yield a flag.
  always_comb begin
    res    = ULA_OUT;
    ovf    = 1'b0;
    is_cmp = 1'b0;
    flag   = 1'b0;
    case (op)
      4'h0: begin res = sum[W-1:0]; ovf = sum[W]; end
      4'h1: begin res = a - b; ovf = (a < b); end
      4'h3: begin
        if (big) begin
          res = '0;
          ovf = |a;
        end else begin
          res = wide[W-1:0];
          ovf = |wide[2*W-1:W];
        end
      end
      4'h4: res = big ? '0 : (a >> b);
      4'h5: res = a | b;
      4'h6: res = a & b;
      4'h7: res = a ^ b;
      4'h8: res = ~b;
      4'h9: begin is_cmp = 1'b1; flag = (a == b); end
      4'hA: begin is_cmp = 1'b1; flag = (a != b); end
      4'hB: begin is_cmp = 1'b1; flag = (a > b);  end
      4'hC: begin is_cmp = 1'b1; flag = (a < b);  end
      4'hD: begin is_cmp = 1'b1; flag = (a >= b); end
      4'hE: begin is_cmp = 1'b1; flag = (a <= b); end
      4'hF: res = '0;
      default: res = ULA_OUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op1          <= '0;
      op2          <= '0;
      op           <= '0;
      cnt          <= '0;
      prod         <= '0;
      mcand        <= '0;
      mplier       <= '0;
      ULA_OUT      <= '0;
      OVERFLOW_OUT <= 1'b0;
      stk          <= '0;
      scnt         <= '0;
      COMP_ERR     <= 1'b0;
    end else begin
      if (!BUSY) begin
        if (CTRL_REG_OP1) op1 <= DATA_IN;
        if (CTRL_REG_OP2) op2 <= DATA_IN;
      end
      case (state)
        S_IDLE: begin
          if (START) begin
            op     <= SEL_ULA;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= {{W{1'b0}}, op2};
            mplier <= op1;
          end
        end
        S_MUL: begin
          prod   <= prod_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            ULA_OUT      <= prod_n[W-1:0];
            OVERFLOW_OUT <= |prod_n[2*W-1:W];
          end
        end
        S_EXEC: begin
          OVERFLOW_OUT <= ovf;
          if (!is_cmp) ULA_OUT <= res;
        end
        default: ;
      endcase
      // Push happens only from EXEC (BUSY=1), so it never meets a pop.
      if (state == S_EXEC && is_cmp) begin
        if (COMP_FULL) begin
          COMP_ERR <= 1'b1;
        end else begin
          stk  <= (stk & ~(COMP_DEPTH'(1) << scnt))
                | (COMP_DEPTH'(flag) << scnt);
          scnt <= scnt + SW'(1);
        end
      end else if (CTRL_COMP_POP && !BUSY) begin
        if (COMP_EMPTY) COMP_ERR <= 1'b1;
        else            scnt <= scnt - SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_block_ula_mc.sv
// Directed-vector bench for block_ula_mc (DATA_WIDTH=8, COMP_DEPTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_block_ula_mc;

  logic       clk;
  logic       rst;
  logic [7:0] DATA_IN;
  logic       CTRL_REG_OP1, CTRL_REG_OP2;
  logic       START;
  logic [3:0] SEL_ULA;
  logic       CTRL_COMP_POP;
  logic [7:0] ULA_OUT;
  logic       OVERFLOW_OUT, BUSY, DONE;
  logic       COMP_TOP, COMP_EMPTY, COMP_FULL, COMP_ERR;

  int total = 0;
  int passed = 0;
  int lat, nb, ndone;

  block_ula_mc #(.DATA_WIDTH(8), .COMP_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .DATA_IN(DATA_IN),
    .CTRL_REG_OP1(CTRL_REG_OP1), .CTRL_REG_OP2(CTRL_REG_OP2),
    .START(START), .SEL_ULA(SEL_ULA), .CTRL_COMP_POP(CTRL_COMP_POP),
    .ULA_OUT(ULA_OUT), .OVERFLOW_OUT(OVERFLOW_OUT),
    .BUSY(BUSY), .DONE(DONE), .COMP_TOP(COMP_TOP),
    .COMP_EMPTY(COMP_EMPTY), .COMP_FULL(COMP_FULL), .COMP_ERR(COMP_ERR)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input logic [7:0] av, input logic [7:0] bv);
    DATA_IN = av; CTRL_REG_OP2 = 1; tick(); CTRL_REG_OP2 = 0;
    DATA_IN = bv; CTRL_REG_OP1 = 1; tick(); CTRL_REG_OP1 = 0;
  endtask

  // Returns in the DONE cycle; lat = cycle number of DONE.
  task automatic run(input logic [3:0] opc, output int l, output int n);
    SEL_ULA = opc; START = 1; tick(); START = 0;
    l = 1; n = 0;
    while (!DONE && l < 40) begin
      if (BUSY) n++;
      tick(); l++;
    end
  endtask

  initial begin
    rst = 1; DATA_IN = 0; CTRL_REG_OP1 = 0; CTRL_REG_OP2 = 0;
    START = 0; SEL_ULA = 0; CTRL_COMP_POP = 0;
    tick(); tick(); rst = 0;

    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ula", ULA_OUT, 0);
    check("rst_ovf", OVERFLOW_OUT, 0);
    check("rst_empty", COMP_EMPTY, 1);
    check("rst_full", COMP_FULL, 0);
    check("rst_err", COMP_ERR, 0);
    check("rst_top", COMP_TOP, 0);

    load(200, 100); run(4'h0, lat, nb);
    check("add_lat", lat, 2);
    check("add_busy", nb, 1);
    check("add_res", ULA_OUT, 44);
    check("add_ovf", OVERFLOW_OUT, 1);
    tick();
    check("add_done_end", DONE, 0);

    load(20, 13); run(4'h2, lat, nb);
    check("mul_lat", lat, 9);
    check("mul_busy", nb, 8);
    check("mul_res", ULA_OUT, 4);
    check("mul_ovf", OVERFLOW_OUT, 1);
    tick();

    load(15, 17); run(4'h2, lat, nb);
    check("mul2_res", ULA_OUT, 8'hFF);
    check("mul2_ovf", OVERFLOW_OUT, 0);
    tick();

    load(8'h81, 1); run(4'h3, lat, nb);
    check("shl_res", ULA_OUT, 8'h02);
    check("shl_ovf", OVERFLOW_OUT, 1);
    tick();

    load(8'h81, 9); run(4'h4, lat, nb);
    check("shr9_res", ULA_OUT, 0);
    check("shr9_ovf", OVERFLOW_OUT, 0);
    tick();

    load(8'h81, 9); run(4'h3, lat, nb);
    check("shl9_res", ULA_OUT, 0);
    check("shl9_ovf", OVERFLOW_OUT, 1);
    tick();

    load(5, 7); run(4'h1, lat, nb);
    check("sub_res", ULA_OUT, 8'hFE);
    check("sub_ovf", OVERFLOW_OUT, 1);
    tick();

    load(8'hF0, 8'h3C); run(4'h7, lat, nb);
    check("xor_res", ULA_OUT, 8'hCC);
    check("xor_ovf", OVERFLOW_OUT, 0);
    tick();

    load(8'h55, 8'h0F); run(4'h8, lat, nb);
    check("not_res", ULA_OUT, 8'hF0);
    tick();

    load(5, 3); run(4'hB, lat, nb);
    check("gt_lat", lat, 2);
    check("gt_ula_hold", ULA_OUT, 8'hF0);
    check("gt_ovf", OVERFLOW_OUT, 0);
    check("gt_top", COMP_TOP, 1);
    check("gt_empty", COMP_EMPTY, 0);
    tick();
    run(4'hC, lat, nb);
    check("lt_top", COMP_TOP, 0);
    tick();
    CTRL_COMP_POP = 1; tick(); CTRL_COMP_POP = 0;
    check("pop1_top", COMP_TOP, 1);
    CTRL_COMP_POP = 1; tick(); CTRL_COMP_POP = 0;
    check("pop2_empty", COMP_EMPTY, 1);
    check("pop2_top", COMP_TOP, 0);
    check("pop2_err", COMP_ERR, 0);
    CTRL_COMP_POP = 1; tick(); CTRL_COMP_POP = 0;
    check("pop_empty_err", COMP_ERR, 1);

    run(4'hF, lat, nb);
    check("nop_res", ULA_OUT, 0);
    check("nop_ovf", OVERFLOW_OUT, 0);
    tick();

    DATA_IN = 7; CTRL_REG_OP1 = 1; CTRL_REG_OP2 = 1; tick();
    CTRL_REG_OP1 = 0; CTRL_REG_OP2 = 0;
    SEL_ULA = 4'h0; START = 1; tick(); START = 0;
    DATA_IN = 8'hFF; CTRL_REG_OP1 = 1; tick(); CTRL_REG_OP1 = 0;
    check("dual_load_done", DONE, 1);
    check("dual_load_res", ULA_OUT, 14);
    tick();
    run(4'h0, lat, nb);
    check("busy_load_ign", ULA_OUT, 14);
    tick();

    rst = 1; tick(); rst = 0;
    check("rst2_err", COMP_ERR, 0);
    load(9, 9);
    for (int i = 0; i < 17; i++) begin
      run(4'h9, lat, nb);
      if (i == 15) begin
        check("stk16_full", COMP_FULL, 1);
        check("stk16_err", COMP_ERR, 0);
      end
      tick();
    end
    check("stk17_full", COMP_FULL, 1);
    check("stk17_err", COMP_ERR, 1);
    check("stk17_top", COMP_TOP, 1);
    CTRL_COMP_POP = 1;
    for (int i = 0; i < 15; i++) tick();
    check("stk15pop_empty", COMP_EMPTY, 0);
    tick(); CTRL_COMP_POP = 0;
    check("stk16pop_empty", COMP_EMPTY, 1);
    check("stk16pop_full", COMP_FULL, 0);
    CTRL_COMP_POP = 1; tick(); CTRL_COMP_POP = 0;
    check("stk_extra_err", COMP_ERR, 1);

    load(1, 2); run(4'h0, lat, nb);
    check("pre_abort_res", ULA_OUT, 3);
    tick();
    load(20, 13);
    SEL_ULA = 4'h2; START = 1;
    tick(); tick(); tick();
    check("abort_busy_c3", BUSY, 1);
    rst = 1; tick(); rst = 0; START = 0;
    check("abort_busy", BUSY, 0);
    check("abort_ula", ULA_OUT, 0);
    check("abort_empty", COMP_EMPTY, 1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (DONE || BUSY) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    check("abort_ula_end", ULA_OUT, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
